// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART echo core.
//   - parity-mode constants
//   - rx / tx state encodings
//   - bit_cnt(): clock cycles per bit
//   - calc_parity(): parity bit to transmit, or to expect, for a data byte
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per bit period (integer division).
    function automatic int bit_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    // Parity bit for a zero-extended byte. Odd: data ^ parity == 1.
    // Even: data ^ parity == 0.
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        logic par;
        if (mode == PAR_ODD) begin
            par = ~(^data);
        end else begin
            par = ^data;
        end
        return par;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO used between the rx and tx engines.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and data (ignored when full unless popping)
//   pop, dout       read request; dout shows the head entry
//   full, empty     status
//   level           current occupancy, 0..DEPTH
// A push while full succeeds only if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] level_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;

    // Status and qualified enables; a same-cycle pop frees a full slot first.
    always_comb begin
        full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                  (wr_ptr_r[AW] != rd_ptr_r[AW]);
        empty_s = (wr_ptr_r == rd_ptr_r);
        rd_en_s = pop && !empty_s;
        wr_en_s = push && (!full_s || rd_en_s);
    end

    // Storage array; no reset needed, the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + PTR_W'(1);
                2'b01:   level_r <= level_r - PTR_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/uart_echo_buf.sv
// Buffered UART echo: receive frames, drop bad ones, queue good bytes,
// retransmit them.
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   uart_rxd            serial input (asynchronous)
//   uart_txd            serial output, idle high
//   tx_hold             1 = do not start new tx frames
//   rx_parity_err       pulse: byte dropped for bad parity
//   rx_frame_err        pulse: byte dropped for stop bit = 0
//   fifo_overflow       pulse: good byte dropped because the FIFO was full
//   fifo_level          FIFO occupancy
//   tx_busy             high from the start bit to the end of the last stop bit
module uart_echo_buf
    import uart_pkg::*;
#(
    parameter int UART_BPS   = 57600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        uart_rxd,
    output logic                        uart_txd,
    input  logic                        tx_hold,
    output logic                        rx_parity_err,
    output logic                        rx_frame_err,
    output logic                        fifo_overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        tx_busy
);

    localparam int BIT_CNT = bit_cnt(CLK_FREQ, UART_BPS);
    localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BIT_CNT / 2);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam bit               PAR_EN    = (PARITY != PAR_NONE);

    // ---------------- rx ----------------
    logic             rxd_meta_r;
    logic             rxd_sync_r;
    logic             rxd_prev_r;
    logic             rx_fall_s;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_idx_r;
    logic [7:0]       rx_data_r;
    logic             rx_par_r;
    logic             push_r;
    logic [7:0]       push_data_r;
    logic             rx_parity_err_r;
    logic             rx_frame_err_r;

    // ---------------- fifo / tx ----------------
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [7:0] fifo_dout_s;
    logic       pop_s;
    logic       fifo_overflow_r;
    tx_state_t        tx_state_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [2:0]       tx_idx_r;
    logic             tx_stop_idx_r;
    logic [7:0]       tx_shreg_r;
    logic             tx_par_r;
    logic             uart_txd_r;
    logic             tx_busy_r;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    assign rx_fall_s = rxd_prev_r & ~rxd_sync_r;

    // Receive FSM. START samples at half a bit; later bits are sampled one
    // full period after that, i.e. mid-bit. STOP evaluates and leaves at
    // mid-stop so the next start edge can be caught immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state_r      <= RX_IDLE;
            rx_cnt_r        <= '0;
            rx_idx_r        <= 3'd0;
            rx_data_r       <= 8'd0;
            rx_par_r        <= 1'b0;
            push_r          <= 1'b0;
            push_data_r     <= 8'd0;
            rx_parity_err_r <= 1'b0;
            rx_frame_err_r  <= 1'b0;
        end else begin
            push_r          <= 1'b0;
            rx_parity_err_r <= 1'b0;
            rx_frame_err_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_idx_r <= 3'd0;
                    if (rx_fall_s) begin
                        rx_state_r <= RX_START;
                        rx_data_r  <= 8'd0;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == CNT_HALF) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r            <= '0;
                        rx_data_r[rx_idx_r] <= rxd_sync_r;
                        if (rx_idx_r == DATA_LAST) begin
                            rx_idx_r   <= 3'd0;
                            rx_state_r <= PAR_EN ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_par_r   <= rxd_sync_r;
                        rx_state_r <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_IDLE;
                        if (!rxd_sync_r) begin
                            rx_frame_err_r <= 1'b1;
                        end else if (PAR_EN && (calc_parity(rx_data_r, PARITY) != rx_par_r)) begin
                            rx_parity_err_r <= 1'b1;
                        end else begin
                            push_r      <= 1'b1;
                            push_data_r <= rx_data_r;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= '0;
                end
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push_r),
        .din   (push_data_r),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Pop in IDLE, or in the last cycle of the final stop bit so that
    // consecutive frames leave no idle gap.
    always_comb begin
        pop_s = 1'b0;
        if (((tx_state_r == TX_IDLE) ||
             ((tx_state_r == TX_STOP) && (tx_cnt_r == CNT_LAST) && (tx_stop_idx_r == STOP_LAST))) &&
            !fifo_empty_s && !tx_hold) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Overflow pulse: a push that the FIFO could not take.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_overflow_r <= 1'b0;
        end else begin
            fifo_overflow_r <= push_r & fifo_full_s & ~pop_s;
        end
    end

    // Transmit FSM. uart_txd and tx_busy are registered and change on the
    // cycle after the decision, so txd falls the cycle after the pop.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_r    <= TX_IDLE;
            tx_cnt_r      <= '0;
            tx_idx_r      <= 3'd0;
            tx_stop_idx_r <= 1'b0;
            tx_shreg_r    <= 8'd0;
            tx_par_r      <= 1'b0;
            uart_txd_r    <= 1'b1;
            tx_busy_r     <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r      <= '0;
                    tx_idx_r      <= 3'd0;
                    tx_stop_idx_r <= 1'b0;
                    if (pop_s) begin
                        tx_shreg_r <= fifo_dout_s;
                        tx_par_r   <= calc_parity(fifo_dout_s, PARITY);
                        tx_state_r <= TX_START;
                        uart_txd_r <= 1'b0;
                        tx_busy_r  <= 1'b1;
                    end else begin
                        uart_txd_r <= 1'b1;
                        tx_busy_r  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx_state_r <= TX_DATA;
                        uart_txd_r <= tx_shreg_r[0];
                        tx_shreg_r <= {1'b0, tx_shreg_r[7:1]};
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_idx_r == DATA_LAST) begin
                            tx_idx_r <= 3'd0;
                            if (PAR_EN) begin
                                tx_state_r <= TX_PARITY;
                                uart_txd_r <= tx_par_r;
                            end else begin
                                tx_state_r <= TX_STOP;
                                uart_txd_r <= 1'b1;
                            end
                        end else begin
                            tx_idx_r   <= tx_idx_r + 3'd1;
                            uart_txd_r <= tx_shreg_r[0];
                            tx_shreg_r <= {1'b0, tx_shreg_r[7:1]};
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_W'(1);
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx_state_r <= TX_STOP;
                        uart_txd_r <= 1'b1;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_stop_idx_r == STOP_LAST) begin
                            tx_stop_idx_r <= 1'b0;
                            if (pop_s) begin
                                tx_shreg_r <= fifo_dout_s;
                                tx_par_r   <= calc_parity(fifo_dout_s, PARITY);
                                tx_state_r <= TX_START;
                                uart_txd_r <= 1'b0;
                            end else begin
                                tx_state_r <= TX_IDLE;
                                uart_txd_r <= 1'b1;
                                tx_busy_r  <= 1'b0;
                            end
                        end else begin
                            tx_stop_idx_r <= tx_stop_idx_r + 1'b1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    uart_txd_r <= 1'b1;
                    tx_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_txd      = uart_txd_r;
    assign tx_busy       = tx_busy_r;
    assign rx_parity_err = rx_parity_err_r;
    assign rx_frame_err  = rx_frame_err_r;
    assign fifo_overflow = fifo_overflow_r;

endmodule

// File: tb/tb_uart_echo_buf.sv
// Self-checking bench for uart_echo_buf: two instances (8N1 and 8E2),
// BIT_CNT = 10, FIFO depth 4. Serial monitors decode uart_txd into queues;
// expectations come from a queue-based model of the echo path.
module tb_uart_echo_buf;

    localparam int CF    = 1_000_000;
    localparam int BPS   = 100_000;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       rxd_a, rxd_b;
    logic       hold_a, hold_b;
    logic       txd_a, txd_b;
    logic       perr_a, perr_b, ferr_a, ferr_b, ovf_a, ovf_b;
    logic [2:0] lvl_a, lvl_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_echo_buf #(.UART_BPS(BPS), .CLK_FREQ(CF), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_a), .uart_txd(txd_a),
        .tx_hold(hold_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a),
        .fifo_overflow(ovf_a), .fifo_level(lvl_a), .tx_busy(busy_a));

    uart_echo_buf #(.UART_BPS(BPS), .CLK_FREQ(CF), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_b), .uart_txd(txd_b),
        .tx_hold(hold_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b),
        .fifo_overflow(ovf_b), .fifo_level(lvl_b), .tx_busy(busy_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and timing observers, sampled on the falling edge.
    int n_perr_a = 0, n_ferr_a = 0, n_ovf_a = 0, n_perr_b = 0;
    int low_a = 0, low_b = 0;
    int lvl_up_cyc = 0;
    int blen = 0, last_blen = 0;
    logic [2:0] prev_lvl_a = 3'd0;
    always @(negedge clk) begin
        if (perr_a === 1'b1) n_perr_a <= n_perr_a + 1;
        if (ferr_a === 1'b1) n_ferr_a <= n_ferr_a + 1;
        if (ovf_a  === 1'b1) n_ovf_a  <= n_ovf_a + 1;
        if (perr_b === 1'b1) n_perr_b <= n_perr_b + 1;
        if (txd_a  === 1'b0) low_a    <= low_a + 1;
        if (txd_b  === 1'b0) low_b    <= low_b + 1;
        if (lvl_a != 3'd0 && prev_lvl_a == 3'd0) lvl_up_cyc <= cyc;
        prev_lvl_a <= lvl_a;
        if (busy_a === 1'b1) begin
            blen <= blen + 1;
        end else begin
            if (blen != 0) last_blen <= blen;
            blen <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- serial monitors ----------------
    logic [7:0] got_a[$], got_b[$];
    bit         ok_a[$], ok_b[$];
    int         st_a[$];

    function automatic logic txd_of(input int w);
        return (w == 0) ? txd_a : txd_b;
    endfunction

    task automatic mon(input int w, input bit has_par, input int nstop);
        forever begin
            logic [7:0] d;
            bit         ok;
            int         sc;
            @(negedge clk);
            while (txd_of(w) !== 1'b0) @(negedge clk);
            sc = cyc;
            repeat (5) @(negedge clk);
            ok = (txd_of(w) === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge clk);
                d[i] = txd_of(w);
            end
            if (has_par) begin
                repeat (10) @(negedge clk);
                ok = ok && (txd_of(w) === (^d));
            end
            for (int s = 0; s < nstop; s++) begin
                repeat (10) @(negedge clk);
                ok = ok && (txd_of(w) === 1'b1);
            end
            if (w == 0) begin
                got_a.push_back(d); ok_a.push_back(ok); st_a.push_back(sc);
            end else begin
                got_b.push_back(d); ok_b.push_back(ok);
            end
        end
    endtask

    initial mon(0, 1'b0, 1);
    initial mon(1, 1'b1, 2);

    // ---------------- stimulus helpers ----------------
    task automatic set_rxd(input int w, input logic v);
        if (w == 0) rxd_a = v; else rxd_b = v;
    endtask

    task automatic uart_send(input int w, input logic [7:0] d, input bit par_en,
                             input logic par_bit, input logic stop_bit);
        set_rxd(w, 1'b0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rxd(w, d[i]);
            repeat (10) @(negedge clk);
        end
        if (par_en) begin
            set_rxd(w, par_bit);
            repeat (10) @(negedge clk);
        end
        set_rxd(w, stop_bit);
        repeat (10) @(negedge clk);
        set_rxd(w, 1'b1);
    endtask

    task automatic wait_got(input int w, input int n, input int budget);
        int k = 0;
        while (((w == 0) ? got_a.size() : got_b.size()) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("echo_timeout", ((w == 0) ? got_a.size() : got_b.size()) >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         snap, snap2, exp_ovf;

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        check_eq("rst_txd_a", txd_a, 1);
        check_eq("rst_txd_b", txd_b, 1);
        check_eq("rst_busy_a", busy_a, 0);
        check_eq("rst_level_a", lvl_a, 0);
        check_eq("rst_pulses_a", {perr_a, ferr_a, ovf_a}, 0);

        // Single 0xA5 frame: latency, content, busy length
        uart_send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_got(0, 1, 300);
        repeat (10) @(negedge clk);
        check_eq("a5_data", got_a[0], 8'hA5);
        check_eq("a5_frame_ok", ok_a[0], 1);
        check_eq("a5_pop_to_txd", st_a[0] - lvl_up_cyc, 1);
        check_eq("a5_busy_len", last_blen, 100);
        got_a.delete(); ok_a.delete(); st_a.delete();

        // Random bytes sent back-to-back
        snap = n_perr_a + n_ferr_a + n_ovf_a;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            uart_send(0, b, 1'b0, 1'b0, 1'b1);
        end
        wait_got(0, 6, 600);
        for (int k = 0; k < 6; k++) begin
            check_eq("rand_data", got_a[k], exp_q[k]);
            check_eq("rand_frame_ok", ok_a[k], 1);
        end
        check_eq("rand_no_err", n_perr_a + n_ferr_a + n_ovf_a - snap, 0);
        got_a.delete(); ok_a.delete(); st_a.delete(); exp_q.delete();
        repeat (20) @(negedge clk);

        // tx_hold: fill past capacity, then drain back-to-back
        hold_a = 1'b1;
        snap = n_ovf_a;
        exp_ovf = 0;
        for (int k = 1; k <= 6; k++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(k));
            else exp_ovf++;
            uart_send(0, 8'(k), 1'b0, 1'b0, 1'b1);
        end
        repeat (10) @(negedge clk);
        check_eq("hold_level", lvl_a, exp_q.size());
        check_eq("hold_ovf", n_ovf_a - snap, exp_ovf);
        check_eq("hold_no_tx", got_a.size(), 0);
        hold_a = 1'b0;
        wait_got(0, 4, 700);
        for (int k = 0; k < 4; k++) check_eq("drain_data", got_a[k], exp_q[k]);
        for (int k = 1; k < 4; k++) check_eq("drain_gap", st_a[k] - st_a[k-1], 100);
        repeat (10) @(negedge clk);
        check_eq("drain_level", lvl_a, 0);
        got_a.delete(); ok_a.delete(); st_a.delete(); exp_q.delete();

        // Start glitch of 3 cycles, then a valid frame
        snap = n_perr_a + n_ferr_a + n_ovf_a;
        rxd_a = 1'b0;
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_level", lvl_a, 0);
        check_eq("glitch_no_tx", got_a.size(), 0);
        check_eq("glitch_no_err", n_perr_a + n_ferr_a + n_ovf_a - snap, 0);
        uart_send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_got(0, 1, 300);
        check_eq("glitch_next_data", got_a[0], 8'h3C);
        got_a.delete(); ok_a.delete(); st_a.delete();
        repeat (20) @(negedge clk);

        // Stop bit 0, then a good frame
        snap = n_ferr_a;
        uart_send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("ferr_pulse", n_ferr_a - snap, 1);
        check_eq("ferr_level", lvl_a, 0);
        check_eq("ferr_no_tx", got_a.size(), 0);
        uart_send(0, 8'hAA, 1'b0, 1'b0, 1'b1);
        wait_got(0, 1, 300);
        check_eq("ferr_next_data", got_a[0], 8'hAA);
        got_a.delete(); ok_a.delete(); st_a.delete();

        // Even parity instance: wrong parity dropped, good ones echoed
        snap  = n_perr_b;
        snap2 = low_b;
        uart_send(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("perr_pulse", n_perr_b - snap, 1);
        check_eq("perr_level", lvl_b, 0);
        check_eq("perr_txd_idle", low_b - snap2, 0);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            uart_send(1, b, 1'b1, ^b, 1'b1);
        end
        wait_got(1, 3, 600);
        for (int k = 0; k < 3; k++) begin
            check_eq("par_data", got_b[k], exp_q[k]);
            check_eq("par_frame_ok", ok_b[k], 1);
        end
        exp_q.delete();

        // Reset in the middle of a tx frame's data bits
        hold_a = 1'b1;
        uart_send(0, 8'h81, 1'b0, 1'b0, 1'b1);
        uart_send(0, 8'h42, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("rst_pre_level", lvl_a, 2);
        hold_a = 1'b0;
        for (int k = 0; k < 50 && busy_a !== 1'b1; k++) @(negedge clk);
        check_eq("rst_pre_busy", busy_a, 1);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_txd", txd_a, 1);
        check_eq("rst_mid_level", lvl_a, 0);
        check_eq("rst_mid_busy", busy_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        got_a.delete(); ok_a.delete(); st_a.delete();
        snap = low_a;
        repeat (200) @(negedge clk);
        check_eq("post_rst_txd_idle", low_a - snap, 0);
        check_eq("post_rst_level", lvl_a, 0);
        check_eq("post_rst_no_tx", got_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_echo_buf.md
Name: uart_echo_buf

Overview:
- Parametrised, buffered UART echo core: receives serial frames on uart_rxd, checks parity and stop bit, queues good bytes in a FIFO, and retransmits them on uart_txd.
- Successor to the direct rx->tx loopback top. Adds configurable data width, parity, stop bits, FIFO depth, a transmit hold control and error/status reporting.
- Sits at chip top between the board UART pins and the rest of the design.

Parameters:
- UART_BPS, 57600, baud rate.
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits generated by tx (1 or 2); rx checks only the first stop bit.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, at least 2.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- uart_rxd  in  1  serial input, asynchronous to sys_clk
- uart_txd  out  1  serial output; idle high
- tx_hold  in  1  1 = do not start new tx frames; a frame in progress completes
- rx_parity_err  out  1  one-cycle pulse when a byte is dropped for bad parity
- rx_frame_err  out  1  one-cycle pulse when a byte is dropped for stop bit = 0
- fifo_overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- tx_busy  out  1  high from the start-bit cycle to the end of the last stop bit

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is sys_rst_n, asynchronous and active-low.
- Reset values: uart_txd=1, all error pulses=0, fifo_level=0, tx_busy=0. The FIFO is emptied and rx/tx return to IDLE.
- Bit period: BIT_CNT = CLK_FREQ/UART_BPS, integer division. The rx and tx bit counters both run from 0 to BIT_CNT-1.
- RX input: uart_rxd passes through a 2-flop synchroniser. A start is detected on a 1->0 edge of the synchronised signal.
- RX states:
  - IDLE -> START on the detected falling edge.
  - START: sample at count BIT_CNT/2. If the sample is 1, this is a glitch; return to IDLE with no output. Otherwise -> DATA.
  - DATA: DATA_BITS samples, LSB first, each taken mid-bit -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: one mid-bit sample -> STOP.
  - STOP: one mid-bit sample, then evaluate the frame and return to IDLE on the same cycle.
- RX hunting: after returning to IDLE at mid-stop-bit, rx can detect the next start edge immediately.
- Frame evaluation, in priority order:
  - Stop bit 0: pulse rx_frame_err, drop the byte.
  - Parity mismatch: pulse rx_parity_err, drop the byte. Odd parity means the XOR of the data bits and the parity bit is 1; even means it is 0.
  - Otherwise push the byte to the FIFO. Data is zero-extended to 8 bits internally.
- FIFO full on push: drop the new byte, pulse fifo_overflow, leave contents and fifo_level unchanged.
- FIFO pointers: $clog2(FIFO_DEPTH)+1 bits, with wrap handled by the extra MSB. Full means equal low bits and differing MSB.
- Simultaneous push and pop: allowed, including when the FIFO is full (the pop frees the slot first, so the push succeeds). fifo_level is unchanged.
- TX states:
  - IDLE: when the FIFO is not empty and tx_hold=0, pop the head byte in that cycle and load the shift register. uart_txd goes low on the next cycle, which enters START.
  - START -> DATA (DATA_BITS, LSB first) -> PARITY (if enabled) -> STOP (STOP_BITS periods of 1) -> IDLE.
  - Back-to-back frames: the next pop may occur in the final cycle of STOP, so frames have no idle gap.
- tx_hold:
  - Sampled only in TX IDLE.
  - Asserting it mid-frame has no effect until that frame ends.
  - While held, rx continues to fill the FIFO.
- Latency: the cycle after a push into an empty FIFO with tx idle and tx_hold=0 is the pop cycle. uart_txd falls on the following cycle, i.e. 2 cycles after the push.
- Reset mid-frame: uart_txd goes to 1 asynchronously and any partial rx byte is discarded.

Decomposition:
- Package uart_pkg:
  - parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - rx and tx state encodings.
  - function bit_cnt(clk_freq, bps).
- Sub-module uart_sync_fifo (params WIDTH, DEPTH): push/pop/full/empty/level, same clock and reset.
- RX and TX engines stay inline in uart_echo_buf.

Test Plan (CLK_FREQ=1_000_000, UART_BPS=100_000 so BIT_CNT=10; DATA_BITS=8, FIFO_DEPTH=4 unless stated):
1. PARITY=0, send 0xA5 with one stop bit -> one push. uart_txd falls 2 cycles after the push, then emits 0,1,0,1,0,0,1,0,1,1 at 10 cycles/bit. tx_busy high for 100 cycles.
2. PARITY=2, send 0x07 with parity bit 0 (wrong) -> rx_parity_err pulses once, fifo_level stays 0, uart_txd stays 1.
3. tx_hold=1, send 0x01..0x06 -> fifo_level reaches 4, fifo_overflow pulses twice (on 0x05 and 0x06). Release tx_hold -> 0x01..0x04 transmitted back-to-back, no idle gap, fifo_level returns to 0.
4. Drive uart_rxd low for 3 cycles only -> no push, no error pulse. Then a valid frame 0x3C -> echoed 0x3C.
5. Send 0x55 with stop bit 0 -> rx_frame_err pulses once, nothing pushed. The next valid frame 0xAA is received and echoed.
6. Assert sys_rst_n=0 mid-way through the DATA bits of a tx frame -> uart_txd=1 within the reset cycle, fifo_level=0. After release, no residual output.
